// File: rtl/clock_pkg.sv
// Shared definitions for the clock subsystem: button bit positions, mode-mux
// FSM states and the all-off level of the active-low FND pins.
package clock_pkg;

  localparam int BTN_L = 0;
  localparam int BTN_U = 1;
  localparam int BTN_D = 2;
  localparam int BTN_R = 3;

  typedef enum logic {
    S_SHOW  = 1'b0,
    S_BLANK = 1'b1
  } state_t;

  // FND pins are active-low, so all ones turns every digit and segment off.
  localparam logic [31:0] FND_BLANK = 32'hFFFF_FFFF;

endpackage

// File: rtl/mode_req_arb.sv
// Mode request arbiter: priority mode_load > btn_mode > auto tick, range check
// on mode_in and wrap of the "next mode" target.
module mode_req_arb #(
  parameter int NUM_MODES = 4,
  parameter int MODE_W    = $clog2(NUM_MODES)
) (
  input  logic              blanking,
  input  logic [MODE_W-1:0] mode,
  input  logic              mode_load,
  input  logic [MODE_W-1:0] mode_in,
  input  logic              btn_mode,
  input  logic              auto_tick,
  output logic              req_valid,
  output logic [MODE_W-1:0] req_target
);

  logic              load_ok;
  logic [MODE_W-1:0] next_mode;

  always_comb begin
    load_ok    = mode_load && (int'(mode_in) < NUM_MODES);
    next_mode  = (int'(mode) >= NUM_MODES - 1) ? '0 : mode + MODE_W'(1);
    req_valid  = 1'b0;
    req_target = mode;
    // While blanking only a valid load matters: it retargets the pending mode.
    if (load_ok) begin
      req_target = mode_in;
      req_valid  = blanking || (mode_in != mode);
    end else if (!blanking && (btn_mode || auto_tick)) begin
      req_target = next_mode;
      req_valid  = (next_mode != mode);
    end
  end

endmodule

// File: rtl/clock_mode_mux.sv
// N-way FND source selector with blanking on mode change, auto-scroll and
// routing of front-panel buttons to the active mode only.
module clock_mode_mux
  import clock_pkg::*;
#(
  parameter int NUM_MODES   = 4,
  parameter int MODE_W      = $clog2(NUM_MODES),
  parameter int COM_W       = 4,
  parameter int SEG_W       = 8,
  parameter int BLANK_CYC   = 1000,
  parameter int AUTO_PERIOD = 100_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       btn_mode,
  input  logic                       mode_load,
  input  logic [MODE_W-1:0]          mode_in,
  input  logic                       auto_en,
  input  logic [NUM_MODES*COM_W-1:0] src_fnd_com,
  input  logic [NUM_MODES*SEG_W-1:0] src_fnd,
  input  logic [3:0]                 btn_in,
  output logic [NUM_MODES*4-1:0]     btn_out,
  output logic [MODE_W-1:0]          mode,
  output logic                       switching,
  output logic [COM_W-1:0]           fnd_com,
  output logic [SEG_W-1:0]           fnd
);

  localparam int BCNT_W = $clog2(BLANK_CYC + 1);
  localparam int ACNT_W = $clog2(AUTO_PERIOD);

  state_t              state;
  logic [MODE_W-1:0]   pending;
  logic [BCNT_W-1:0]   blank_cnt;
  logic [ACNT_W-1:0]   auto_cnt;
  logic                auto_tick;
  logic                req_valid;
  logic [MODE_W-1:0]   req_target;
  logic [MODE_W-1:0]   fin_mode;
  logic [MODE_W-1:0]   show_mode;
  logic [COM_W-1:0]    show_com;
  logic [SEG_W-1:0]    show_seg;
  logic [NUM_MODES*4-1:0] btn_route;

  assign auto_tick = (state == S_SHOW) && auto_en &&
                     (auto_cnt == ACNT_W'(AUTO_PERIOD - 1));

  mode_req_arb #(
    .NUM_MODES (NUM_MODES),
    .MODE_W    (MODE_W)
  ) u_arb (
    .blanking   (state == S_BLANK),
    .mode       (mode),
    .mode_load  (mode_load),
    .mode_in    (mode_in),
    .btn_mode   (btn_mode),
    .auto_tick  (auto_tick),
    .req_valid  (req_valid),
    .req_target (req_target)
  );

  // A load in the last blank cycle still wins over the older pending target.
  always_comb begin
    fin_mode  = req_valid ? req_target : pending;
    show_mode = (state == S_BLANK) ? fin_mode : mode;
    show_com  = src_fnd_com[int'(show_mode)*COM_W +: COM_W];
    show_seg  = src_fnd[int'(show_mode)*SEG_W +: SEG_W];
    btn_route = '0;
    for (int k = 0; k < NUM_MODES; k++) begin
      if (MODE_W'(k) == mode) btn_route[k*4 +: 4] = btn_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      auto_cnt <= '0;
    end else if (!auto_en || ((state == S_SHOW) && req_valid)) begin
      auto_cnt <= '0;
    end else if (state == S_SHOW) begin
      auto_cnt <= auto_tick ? '0 : auto_cnt + ACNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_SHOW;
      mode      <= '0;
      pending   <= '0;
      blank_cnt <= '0;
      switching <= 1'b0;
      fnd_com   <= COM_W'(FND_BLANK);
      fnd       <= SEG_W'(FND_BLANK);
      btn_out   <= '0;
    end else begin
      case (state)
        S_SHOW: begin
          if (req_valid) begin
            state     <= S_BLANK;
            pending   <= req_target;
            blank_cnt <= BCNT_W'(BLANK_CYC - 1);
            switching <= 1'b1;
            fnd_com   <= COM_W'(FND_BLANK);
            fnd       <= SEG_W'(FND_BLANK);
            btn_out   <= '0;
          end else begin
            fnd_com   <= show_com;
            fnd       <= show_seg;
            btn_out   <= btn_route;
          end
        end
        S_BLANK: begin
          btn_out <= '0;
          if (req_valid) pending <= req_target;
          if (blank_cnt == '0) begin
            state     <= S_SHOW;
            mode      <= fin_mode;
            switching <= 1'b0;
            fnd_com   <= show_com;
            fnd       <= show_seg;
          end else begin
            blank_cnt <= blank_cnt - BCNT_W'(1);
          end
        end
        default: state <= S_SHOW;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_mode_mux.sv
// Directed bench for clock_mode_mux: reset, blanking, request priority,
// invalid loads, button routing, auto-scroll and reset during blanking.
module tb_clock_mode_mux;
  import clock_pkg::*;

  localparam int NM  = 4;
  localparam int MW  = 3;
  localparam int BC  = 3;
  localparam int AP  = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic            btn_mode;
  logic            mode_load;
  logic [MW-1:0]   mode_in;
  logic            auto_en;
  logic [NM*4-1:0] src_fnd_com;
  logic [NM*8-1:0] src_fnd;
  logic [3:0]      btn_in;
  logic [NM*4-1:0] btn_out;
  logic [MW-1:0]   mode;
  logic            switching;
  logic [3:0]      fnd_com;
  logic [7:0]      fnd;

  int n_checks = 0;
  int n_pass   = 0;
  logic [MW-1:0] exp_q[$];

  // Source k patterns: commons {7,B,D,E}, segments {99,B0,A4,C0} for k=3..0.
  localparam logic [15:0] SRC_COM = 16'h7BDE;
  localparam logic [31:0] SRC_SEG = 32'h99B0_A4C0;

  clock_mode_mux #(
    .NUM_MODES   (NM),
    .MODE_W      (MW),
    .COM_W       (4),
    .SEG_W       (8),
    .BLANK_CYC   (BC),
    .AUTO_PERIOD (AP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_mode    (btn_mode),
    .mode_load   (mode_load),
    .mode_in     (mode_in),
    .auto_en     (auto_en),
    .src_fnd_com (src_fnd_com),
    .src_fnd     (src_fnd),
    .btn_in      (btn_in),
    .btn_out     (btn_out),
    .mode        (mode),
    .switching   (switching),
    .fnd_com     (fnd_com),
    .fnd         (fnd)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Request inputs are already set; they are sampled on the first step.
  task automatic switch_and_check(input string tag, input logic [MW-1:0] exp_mode,
                                  input logic [7:0] exp_fnd);
    for (int i = 0; i < BC; i++) begin
      step();
      btn_mode  = 1'b0;
      mode_load = 1'b0;
      mode_in   = '0;
      check({tag, "_sw"}, 32'(switching), 32'd1);
      check({tag, "_blank"}, 32'(fnd), 32'hFF);
    end
    step();
    check({tag, "_mode"}, 32'(mode), 32'(exp_mode));
    check({tag, "_fnd"}, 32'(fnd), 32'(exp_fnd));
    check({tag, "_sw_off"}, 32'(switching), 32'd0);
  endtask

  initial begin
    int cyc;
    int last_chg;
    logic [MW-1:0] prev_mode;

    rst = 1'b0; btn_mode = 1'b0; mode_load = 1'b0; mode_in = '0;
    auto_en = 1'b0; btn_in = '0;
    src_fnd_com = SRC_COM;
    src_fnd     = SRC_SEG;

    // reset state
    step(); step();
    check("rst_com", 32'(fnd_com), 32'hF);
    check("rst_fnd", 32'(fnd), 32'hFF);
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_sw", 32'(switching), 32'd0);
    check("rst_btn", 32'(btn_out), 32'd0);
    rst = 1'b1;
    step();
    check("rel_fnd", 32'(fnd), 32'hC0);
    check("rel_com", 32'(fnd_com), 32'hE);

    // load to mode 3, then btn_mode wraps 3 -> 0
    mode_load = 1'b1; mode_in = 3'd3;
    switch_and_check("load3", 3'd3, 8'h99);
    btn_mode = 1'b1;
    switch_and_check("wrap", 3'd0, 8'hC0);

    // load beats btn_mode
    mode_load = 1'b1; mode_in = 3'd2; btn_mode = 1'b1;
    switch_and_check("prio", 3'd2, 8'hB0);

    // out-of-range load ignored
    mode_load = 1'b1; mode_in = 3'd5;
    step();
    mode_load = 1'b0; mode_in = '0;
    check("bad_sw", 32'(switching), 32'd0);
    step();
    check("bad_sw2", 32'(switching), 32'd0);
    check("bad_mode", 32'(mode), 32'd2);
    check("bad_fnd", 32'(fnd), 32'hB0);

    // out-of-range load falls through to btn_mode: 2 -> 3
    mode_load = 1'b1; mode_in = 3'd7; btn_mode = 1'b1;
    switch_and_check("bad_btn", 3'd3, 8'h99);
    btn_mode = 1'b1;
    switch_and_check("wrap2", 3'd0, 8'hC0);

    // load of the current mode: no blanking
    mode_load = 1'b1; mode_in = 3'd0;
    step();
    mode_load = 1'b0;
    check("same_sw", 32'(switching), 32'd0);
    check("same_fnd", 32'(fnd), 32'hC0);
    check("same_mode", 32'(mode), 32'd0);

    // override pending during BLANK, buttons dropped while blanking
    btn_mode = 1'b1;
    step();
    btn_mode = 1'b0;
    mode_load = 1'b1; mode_in = 3'd3; btn_in = 4'b0001;
    step();
    mode_load = 1'b0; mode_in = '0; btn_in = '0;
    check("ovr_sw", 32'(switching), 32'd1);
    check("ovr_btn", 32'(btn_out), 32'd0);
    step();
    check("ovr_sw2", 32'(switching), 32'd1);
    step();
    check("ovr_mode", 32'(mode), 32'd3);
    check("ovr_fnd", 32'(fnd), 32'h99);

    // routing: R in mode 3, then L in mode 1
    btn_in = 4'b1000;
    step();
    btn_in = '0;
    check("route3", 32'(btn_out), 32'h8000);
    mode_load = 1'b1; mode_in = 3'd1;
    switch_and_check("load1", 3'd1, 8'hA4);
    btn_in = 4'(1 << BTN_L);
    step();
    btn_in = '0;
    check("route1", 32'(btn_out), 32'h0010);
    step();
    check("route1_clr", 32'(btn_out), 32'h0000);

    // auto-scroll: 1 -> 2 -> 3 -> 0 -> 1, one change every AP+BC cycles
    exp_q = {3'd2, 3'd3, 3'd0, 3'd1};
    auto_en = 1'b1;
    cyc = 0; last_chg = 0; prev_mode = mode;
    while (exp_q.size() > 0 && cyc < 100) begin
      step();
      cyc++;
      if (mode !== prev_mode) begin
        check("auto_mode", 32'(mode), 32'(exp_q.pop_front()));
        check("auto_period", 32'(cyc - last_chg), 32'(AP + BC));
        last_chg = cyc;
        prev_mode = mode;
      end
    end
    check("auto_done", 32'(exp_q.size()), 32'd0);

    // reset in the middle of the 1 -> 2 blank
    cyc = 0;
    while (switching !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    check("auto_blank", 32'(switching), 32'd1);
    step();
    rst = 1'b0;
    step();
    check("abort_mode", 32'(mode), 32'd0);
    check("abort_sw", 32'(switching), 32'd0);
    check("abort_fnd", 32'(fnd), 32'hFF);
    rst = 1'b1; auto_en = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("abort_hold", 32'(mode), 32'd0);
    check("abort_src0", 32'(fnd), 32'hC0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
